mips_inst_encoder: RTL and testbench
====================================

// Module: mips_inst_encoder
// PURPOSE
//   Encoder counterpart of the instruction decoder. Takes symbolic instruction descriptors
//   (mnemonic code and fields) over a valid/ready handshake and packs each one into a
//   32-bit MIPS word. Writes the words to consecutive IMEM word addresses.
//   Used as the program loader in front of IMEM for the static-pipeline CPU and its benches.
//   Covers the same 31-instruction subset the CPU decodes.
// PARAMETERS
//   IMEM_AW    11  IMEM word-address width; capacity is 2**IMEM_AW words
//   BASE_ADDR  0   first IMEM word address written in each session
// PORTS
//   clk          in   1        clock, all state updates on rising edge
//   rst          in   1        synchronous, active-high reset
//   start        in   1        begin a load session; honoured only in IDLE or DONE
//   in_valid     in   1        descriptor valid
//   in_ready     out  1        descriptor accepted when in_valid && in_ready
//   in_mnem      in   5        0 ADD,1 ADDU,2 SUB,3 SUBU,4 AND,5 OR,6 XOR,7 NOR,8 SLT,9 SLTU,
//                              10 SLL,11 SRL,12 SRA,13 SLLV,14 SRLV,15 SRAV,16 JR,17 ADDI,
//                              18 ADDIU,19 ANDI,20 ORI,21 XORI,22 LW,23 SW,24 BEQ,25 BNE,
//                              26 SLTI,27 SLTIU,28 LUI,29 J,30 JAL; 31 = illegal
//   in_rs/in_rt/in_rd/in_shamt  in 5 each   register and shift-amount fields
//   in_imm       in   16       immediate or branch offset, passed through raw
//   in_target    in   26       jump target field
//   in_last      in   1        final descriptor of the session
//   imem_we      out  1        IMEM write strobe, one cycle per word
//   imem_addr    out  IMEM_AW  IMEM word address
//   imem_wdata   out  32       encoded instruction
//   busy         out  1        high in LOAD or WRITE
//   done         out  1        high in DONE
//   err_illegal  out  1        sticky: an illegal mnemonic was consumed
//   err_overflow out  1        sticky: a descriptor arrived with IMEM full
//   count        out  IMEM_AW+1  number of words written this session
// BEHAVIOUR
//   Reset: state IDLE.
//     imem_we, in_ready, busy, done, err_*, count = 0; imem_addr = BASE_ADDR; imem_wdata = 0.
//   FSM states and transitions:
//     IDLE --start--> LOAD.
//     LOAD: in_ready = 1. On accept, register the encoded word, then:
//       - legal mnemonic and count < 2**IMEM_AW: go to WRITE.
//       - illegal mnemonic: set err_illegal; no write; go to DONE if in_last, else stay in LOAD.
//       - count == 2**IMEM_AW: set err_overflow; no write; go to DONE.
//     WRITE: imem_we = 1 for exactly one cycle at the current imem_addr.
//       Next edge: imem_addr += 1, count += 1; go to DONE if the latched last is set, else LOAD.
//     DONE: held until start.
//       start in IDLE or DONE: imem_addr = BASE_ADDR, count = 0, err_* cleared, go to LOAD.
//     start is ignored in LOAD and WRITE.
//   Timing: accept at edge N -> imem_we high in cycle N+1; throughput one word per 2 cycles.
//     in_ready is 0 in WRITE.
//   Encoding:
//     R-type = {6'b0, rs, rt, rd, shamt, func}, with func:
//       ADD 20, ADDU 21, SUB 22, SUBU 23, AND 24, OR 25, XOR 26, NOR 27, SLT 2A, SLTU 2B,
//       SLL 00, SRL 02, SRA 03, SLLV 04, SRLV 06, SRAV 07, JR 08 (hex).
//     Forced-zero fields:
//       - SLL/SRL/SRA: rs = 0.
//       - All other R-type: shamt = 0.
//       - JR: rt = rd = shamt = 0.
//     I-type = {op, rs, rt, imm}, with op:
//       ADDI 08, ADDIU 09, ANDI 0C, ORI 0D, XORI 0E, LW 23, SW 2B, BEQ 04, BNE 05,
//       SLTI 0A, SLTIU 0B, LUI 0F. LUI forces rs = 0.
//     J-type = {op, target}: J 02, JAL 03.
//   imem_addr wraps modulo 2**IMEM_AW only through BASE_ADDR offset; the count limit governs
//     overflow, never the address.
//   rst in any state, including mid-WRITE: next cycle imem_we = 0 and all reset values apply.
// TESTING
//   start; ADD rs1 rt2 rd3 last -> imem_we 1 cycle, addr 0, wdata 0x00221820; done = 1.
//   ADDI rt8 imm FFFF -> 0x2008FFFF; then LUI rs5 rt1 imm 1234 -> 0x3C011234 (rs forced 0).
//   SLL rs7 rt3 rd2 shamt4 -> 0x00031100; JR rs31 -> 0x03E00008;
//     JAL target 0x0100000 -> 0x0C100000; addrs 0,1,2.
//   ADD, mnem 31, ORI(last) -> two writes at addr 0,1; err_illegal = 1; count = 2; done.
//   IMEM_AW = 2, five descriptors -> writes at addr 0..3; 5th not written; err_overflow = 1; done.
//   rst during WRITE -> imem_we 0 next cycle, IDLE, count 0.
//     in_valid held in IDLE without start -> in_ready 0, no write.

Source files
------------

// File: rtl/mips_inst_encoder.sv
// Program loader: packs symbolic MIPS descriptors into 32-bit words and
// writes them to consecutive IMEM word addresses over a valid/ready handshake.
module mips_inst_encoder #(
  parameter int unsigned IMEM_AW   = 11,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         in_mnem,
  input  logic [4:0]         in_rs,
  input  logic [4:0]         in_rt,
  input  logic [4:0]         in_rd,
  input  logic [4:0]         in_shamt,
  input  logic [15:0]        in_imm,
  input  logic [25:0]        in_target,
  input  logic               in_last,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               busy,
  output logic               done,
  output logic               err_illegal,
  output logic               err_overflow,
  output logic [IMEM_AW:0]   count
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_e;

  typedef enum logic [4:0] {
    MN_ADD, MN_ADDU, MN_SUB, MN_SUBU, MN_AND, MN_OR, MN_XOR, MN_NOR,
    MN_SLT, MN_SLTU, MN_SLL, MN_SRL, MN_SRA, MN_SLLV, MN_SRLV, MN_SRAV,
    MN_JR, MN_ADDI, MN_ADDIU, MN_ANDI, MN_ORI, MN_XORI, MN_LW, MN_SW,
    MN_BEQ, MN_BNE, MN_SLTI, MN_SLTIU, MN_LUI, MN_J, MN_JAL, MN_ILLEGAL
  } mnem_e;

  localparam logic [IMEM_AW:0] CAP = {1'b1, {IMEM_AW{1'b0}}};

  state_e      state, state_n;
  mnem_e       mnem;
  logic [31:0] enc_word;
  logic        enc_legal;
  logic        last_q;
  logic        accept;
  logic        full;
  logic        restart;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  assign mnem = mnem_e'(in_mnem);

  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (mnem)
      MN_ADD:   enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h20);
      MN_ADDU:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h21);
      MN_SUB:   enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h22);
      MN_SUBU:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h23);
      MN_AND:   enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h24);
      MN_OR:    enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h25);
      MN_XOR:   enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h26);
      MN_NOR:   enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h27);
      MN_SLT:   enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h2A);
      MN_SLTU:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h2B);
      MN_SLL:   enc_word = r_word(5'd0, in_rt, in_rd, in_shamt, 6'h00);
      MN_SRL:   enc_word = r_word(5'd0, in_rt, in_rd, in_shamt, 6'h02);
      MN_SRA:   enc_word = r_word(5'd0, in_rt, in_rd, in_shamt, 6'h03);
      MN_SLLV:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h04);
      MN_SRLV:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h06);
      MN_SRAV:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h07);
      MN_JR:    enc_word = r_word(in_rs, 5'd0, 5'd0, 5'd0, 6'h08);
      MN_ADDI:  enc_word = i_word(6'h08, in_rs, in_rt, in_imm);
      MN_ADDIU: enc_word = i_word(6'h09, in_rs, in_rt, in_imm);
      MN_ANDI:  enc_word = i_word(6'h0C, in_rs, in_rt, in_imm);
      MN_ORI:   enc_word = i_word(6'h0D, in_rs, in_rt, in_imm);
      MN_XORI:  enc_word = i_word(6'h0E, in_rs, in_rt, in_imm);
      MN_LW:    enc_word = i_word(6'h23, in_rs, in_rt, in_imm);
      MN_SW:    enc_word = i_word(6'h2B, in_rs, in_rt, in_imm);
      MN_BEQ:   enc_word = i_word(6'h04, in_rs, in_rt, in_imm);
      MN_BNE:   enc_word = i_word(6'h05, in_rs, in_rt, in_imm);
      MN_SLTI:  enc_word = i_word(6'h0A, in_rs, in_rt, in_imm);
      MN_SLTIU: enc_word = i_word(6'h0B, in_rs, in_rt, in_imm);
      MN_LUI:   enc_word = i_word(6'h0F, 5'd0, in_rt, in_imm);
      MN_J:     enc_word = {6'h02, in_target};
      MN_JAL:   enc_word = {6'h03, in_target};
      default:  enc_legal = 1'b0;
    endcase
  end

  assign accept  = (state == S_LOAD) && in_valid;
  assign full    = (count == CAP);
  assign restart = ((state == S_IDLE) || (state == S_DONE)) && start;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_LOAD;
      S_LOAD: begin
        if (in_valid) begin
          // Illegal takes priority: it never writes, so capacity is irrelevant to it.
          if (!enc_legal)  state_n = in_last ? S_DONE : S_LOAD;
          else if (full)   state_n = S_DONE;
          else             state_n = S_WRITE;
        end
      end
      S_WRITE: state_n = last_q ? S_DONE : S_LOAD;
      S_DONE:  if (start) state_n = S_LOAD;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      imem_addr    <= IMEM_AW'(BASE_ADDR);
      imem_wdata   <= '0;
      count        <= '0;
      err_illegal  <= 1'b0;
      err_overflow <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state <= state_n;
      if (restart) begin
        imem_addr    <= IMEM_AW'(BASE_ADDR);
        count        <= '0;
        err_illegal  <= 1'b0;
        err_overflow <= 1'b0;
      end
      if (accept) begin
        imem_wdata <= enc_word;
        last_q     <= in_last;
        if (!enc_legal) err_illegal  <= 1'b1;
        else if (full)  err_overflow <= 1'b1;
      end
      if (state == S_WRITE) begin
        imem_addr <= imem_addr + IMEM_AW'(1);
        count     <= count + (IMEM_AW+1)'(1);
      end
    end
  end

  assign imem_we  = (state == S_WRITE);
  assign in_ready = (state == S_LOAD);
  assign busy     = (state == S_LOAD) || (state == S_WRITE);
  assign done     = (state == S_DONE);

endmodule

// File: tb/tb_mips_inst_encoder.sv
// Directed bench for mips_inst_encoder: encodings, session flow, error flags,
// overflow on a small IMEM, and reset during a write.
module tb_mips_inst_encoder;

  logic        clk = 1'b0;
  logic        rst, start, start2, in_valid, in_last;
  logic [4:0]  in_mnem, in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;

  logic        in_ready, imem_we, busy, done, err_illegal, err_overflow;
  logic [10:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [11:0] count;

  logic        in_ready2, imem_we2, busy2, done2, err_illegal2, err_overflow2;
  logic [1:0]  imem_addr2;
  logic [31:0] imem_wdata2;
  logic [2:0]  count2;

  logic        use2 = 1'b0;
  int          total = 0;
  int          fails = 0;

  logic [31:0] wa[$], wd[$], wa2[$], wd2[$];

  always #5 clk = ~clk;

  mips_inst_encoder #(.IMEM_AW(11), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err_illegal(err_illegal), .err_overflow(err_overflow),
    .count(count)
  );

  mips_inst_encoder #(.IMEM_AW(2), .BASE_ADDR(0)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid), .in_ready(in_ready2),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
    .busy(busy2), .done(done2), .err_illegal(err_illegal2), .err_overflow(err_overflow2),
    .count(count2)
  );

  always @(negedge clk) begin
    if (imem_we)  begin wa.push_back(32'(imem_addr));  wd.push_back(imem_wdata);  end
    if (imem_we2) begin wa2.push_back(32'(imem_addr2)); wd2.push_back(imem_wdata2); end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [4:0] m, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                      input logic [25:0] tgt, input logic last);
    int n = 0;
    in_mnem = m; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
    in_imm = imm; in_target = tgt; in_last = last; in_valid = 1'b1;
    @(negedge clk);
    while (!(use2 ? in_ready2 : in_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(n < 20), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(use2 ? done2 : done) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", 32'(n < 20), 32'd1);
  endtask

  task automatic pulse_start();
    if (use2) start2 = 1'b1; else start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    start2 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_mnem = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
    in_imm = '0; in_target = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_errs", {30'd0, err_illegal, err_overflow}, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    rst = 1'b0;

    // valid held in IDLE without start
    in_valid = 1'b1; in_mnem = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_ready", 32'(in_ready), 32'd0);
    chk("idle_nowrite", 32'(wa.size()), 32'd0);
    in_valid = 1'b0;

    // session 1: single ADD (shamt junk must be forced to zero)
    pulse_start();
    chk("s1_busy", 32'(busy), 32'd1);
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd9, 16'h0, 26'h0, 1'b1);
    chk("s1_we", 32'(imem_we), 32'd1);
    chk("s1_ready_in_write", 32'(in_ready), 32'd0);
    chk("s1_addr", 32'(imem_addr), 32'd0);
    chk("s1_wdata", imem_wdata, 32'h00221820);
    @(posedge clk); #1;
    chk("s1_we_off", 32'(imem_we), 32'd0);
    chk("s1_done", 32'(done), 32'd1);
    chk("s1_count", 32'(count), 32'd1);
    chk("s1_nwrites", 32'(wa.size()), 32'd1);

    // session 2: ADDI, LUI (rs forced 0)
    wa.delete(); wd.delete();
    pulse_start();
    chk("s2_count_clr", 32'(count), 32'd0);
    send(5'd17, 5'd0, 5'd8, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1'b0);
    send(5'd28, 5'd5, 5'd1, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b1);
    wait_done();
    chk("s2_nwrites", 32'(wd.size()), 32'd2);
    if (wd.size() == 2) begin
      chk("s2_addi", wd[0], 32'h2008FFFF);
      chk("s2_lui", wd[1], 32'h3C011234);
      chk("s2_a1", wa[1], 32'd1);
    end

    // session 3: SLL, JR (junk rt/rd/shamt), JAL
    wa.delete(); wd.delete();
    pulse_start();
    send(5'd10, 5'd7, 5'd3, 5'd2, 5'd4, 16'h0, 26'h0, 1'b0);
    send(5'd16, 5'd31, 5'd5, 5'd6, 5'd7, 16'h0, 26'h0, 1'b0);
    send(5'd30, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000, 1'b1);
    wait_done();
    chk("s3_nwrites", 32'(wd.size()), 32'd3);
    if (wd.size() == 3) begin
      chk("s3_sll", wd[0], 32'h00031100);
      chk("s3_jr", wd[1], 32'h03E00008);
      chk("s3_jal", wd[2], 32'h0C100000);
      chk("s3_a0", wa[0], 32'd0);
      chk("s3_a2", wa[2], 32'd2);
    end
    chk("s3_count", 32'(count), 32'd3);

    // session 4: ADD, illegal, ORI(last)
    wa.delete(); wd.delete();
    pulse_start();
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
    send(5'd31, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1, 1'b0);
    send(5'd20, 5'd2, 5'd3, 5'd0, 5'd0, 16'h00FF, 26'h0, 1'b1);
    wait_done();
    chk("s4_nwrites", 32'(wd.size()), 32'd2);
    if (wd.size() == 2) begin
      chk("s4_add", wd[0], 32'h00221820);
      chk("s4_ori", wd[1], 32'h344300FF);
      chk("s4_a1", wa[1], 32'd1);
    end
    chk("s4_illegal", 32'(err_illegal), 32'd1);
    chk("s4_overflow", 32'(err_overflow), 32'd0);
    chk("s4_count", 32'(count), 32'd2);

    // restart clears sticky flags; then reset in the middle of a write
    pulse_start();
    chk("s5_illegal_clr", 32'(err_illegal), 32'd0);
    send(5'd1, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, 1'b0);
    chk("s5_we", 32'(imem_we), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstw_we", 32'(imem_we), 32'd0);
    chk("rstw_busy", 32'(busy), 32'd0);
    chk("rstw_count", 32'(count), 32'd0);
    chk("rstw_addr", 32'(imem_addr), 32'd0);
    rst = 1'b0;

    // overflow on a 4-word IMEM
    use2 = 1'b1;
    wa2.delete(); wd2.delete();
    pulse_start();
    for (int k = 0; k < 5; k++) send(5'd1, 5'd0, 5'd0, 5'(k + 1), 5'd0, 16'h0, 26'h0, 1'b0);
    wait_done();
    chk("ov_nwrites", 32'(wa2.size()), 32'd4);
    if (wa2.size() == 4) begin
      chk("ov_a3", wa2[3], 32'd3);
      chk("ov_d3", wd2[3], 32'h00002021);
    end
    chk("ov_flag", 32'(err_overflow2), 32'd1);
    chk("ov_count", 32'(count2), 32'd4);
    chk("ov_illegal", 32'(err_illegal2), 32'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
